// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite register responder: address/data words,
// response codes and the byte-address LSB used for register indexing.
package axi_lite_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int STRB_W   = DATA_W / 8;
  localparam int ADDR_LSB = 2;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

endpackage

// File: rtl/axi_lite_regfile.sv
// Register array: one byte-masked write port, one combinational read port.
// Strobe masking is honoured only when AXI_LITE_STRB_EN is defined.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int    NUM_REGS  = 16,
  parameter data_t RESET_VAL = '0,
  parameter int    IDX_W     = $clog2(NUM_REGS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  data_t             i_wdata,
  input  logic [STRB_W-1:0] i_wstrb,
  input  logic [IDX_W-1:0]  i_ridx,
  output data_t             o_rdata
);

  data_t             r_mem [NUM_REGS];
  logic [STRB_W-1:0] w_be;

`ifdef AXI_LITE_STRB_EN
  assign w_be = i_wstrb;
`else
  logic w_unused_strb;
  assign w_unused_strb = ^i_wstrb;
  assign w_be          = '1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= RESET_VAL;
    end else if (i_we) begin
      for (int b = 0; b < STRB_W; b++)
        if (w_be[b]) r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  // Read sees the pre-edge contents, so a same-edge write is not forwarded.
  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder backed by NUM_REGS 32-bit registers; independent
// write and read FSMs. Optional byte strobes: define AXI_LITE_STRB_EN.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int    NUM_REGS  = 16,
  parameter data_t RESET_VAL = 32'h0000_0000
) (
  input  logic              aclk,
  input  logic              areset,
  input  addr_t             awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  data_t             wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  addr_t             araddr,
  input  logic              arvalid,
  output logic              arready,
  output data_t             rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready
);

  localparam int IDX_W = $clog2(NUM_REGS);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic is_oob(input addr_t a);
    return a >= addr_t'(NUM_REGS * 4);
  endfunction

  // ---------------- write path ----------------
  w_state_t          r_w_state, w_w_state_nxt;
  logic              r_aw_held, r_w_held;
  addr_t             r_awaddr;
  data_t             r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  resp_t             r_bresp;

  logic              w_aw_hs, w_w_hs, w_commit, w_wr_oob;
  addr_t             w_waddr;
  data_t             w_wdata;
  logic [STRB_W-1:0] w_wstrb;

  assign w_aw_hs  = awvalid && awready;
  assign w_w_hs   = wvalid && wready;
  // Either half may arrive this cycle or be waiting from an earlier one.
  assign w_waddr  = r_aw_held ? r_awaddr : awaddr;
  assign w_wdata  = r_w_held  ? r_wdata  : wdata;
  assign w_wstrb  = r_w_held  ? r_wstrb  : wstrb;
  assign w_commit = (r_w_state == W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_wr_oob = is_oob(w_waddr);

  always_comb begin
    w_w_state_nxt = r_w_state;
    awready       = 1'b0;
    wready        = 1'b0;
    bvalid        = (r_w_state == W_RESP);
    case (r_w_state)
      W_IDLE: begin
        awready = !r_aw_held && !areset;
        wready  = !r_w_held  && !areset;
        if (w_commit) w_w_state_nxt = W_RESP;
      end
      W_RESP: if (bready) w_w_state_nxt = W_IDLE;
      default: w_w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_w_state <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= OKAY;
    end else begin
      r_w_state <= w_w_state_nxt;
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= wdata;
        r_wstrb  <= wstrb;
      end
      if (w_commit) r_bresp <= w_wr_oob ? SLVERR : OKAY;
      if (r_w_state == W_RESP && bready) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
    end
  end

  assign bresp = r_bresp;

  // ---------------- read path ----------------
  r_state_t r_r_state, w_r_state_nxt;
  data_t    r_rdata, w_rf_rdata;
  resp_t    r_rresp;
  logic     w_ar_hs, w_rd_oob;

  assign w_ar_hs  = arvalid && arready;
  assign w_rd_oob = is_oob(araddr);

  always_comb begin
    w_r_state_nxt = r_r_state;
    arready       = 1'b0;
    rvalid        = (r_r_state == R_DATA);
    case (r_r_state)
      R_IDLE: begin
        arready = !areset;
        if (arvalid && !areset) w_r_state_nxt = R_DATA;
      end
      R_DATA: if (rready) w_r_state_nxt = R_IDLE;
      default: w_r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_r_state <= R_IDLE;
      r_rdata   <= '0;
      r_rresp   <= OKAY;
    end else begin
      r_r_state <= w_r_state_nxt;
      if (w_ar_hs) begin
        r_rdata <= w_rd_oob ? '0 : w_rf_rdata;
        r_rresp <= w_rd_oob ? SLVERR : OKAY;
      end
    end
  end

  assign rdata = r_rdata;
  assign rresp = r_rresp;

  axi_lite_regfile #(
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL (RESET_VAL),
    .IDX_W     (IDX_W)
  ) u_regfile (
    .i_clk   (aclk),
    .i_rst   (areset),
    .i_we    (w_commit && !w_wr_oob),
    .i_widx  (w_waddr[ADDR_LSB +: IDX_W]),
    .i_wdata (w_wdata),
    .i_wstrb (w_wstrb),
    .i_ridx  (araddr[ADDR_LSB +: IDX_W]),
    .o_rdata (w_rf_rdata)
  );

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Self-checking bench for axi_lite_slave_regs: a register model feeds
// expected B/R responses into queues that are popped as the DUT answers.
module tb_axi_lite_slave_regs;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mdl [16];
  logic [1:0]  q_b [$];
  logic [33:0] q_r [$];

  always #5 aclk = ~aclk;

  axi_lite_slave_regs dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge aclk);
    @(negedge aclk);
  endtask

  // Model side of a write: expected bresp plus the register update.
  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a >= 32'd64) q_b.push_back(2'b10);
    else begin
      q_b.push_back(2'b00);
`ifdef AXI_LITE_STRB_EN
      for (int b = 0; b < 4; b++) if (s[b]) mdl[a[5:2]][8*b +: 8] = d[8*b +: 8];
`else
      mdl[a[5:2]] = d;
`endif
    end
  endtask

  task automatic push_rd(input logic [31:0] a);
    if (a >= 32'd64) q_r.push_back({2'b10, 32'h0});
    else             q_r.push_back({2'b00, mdl[a[5:2]]});
  endtask

  // Called at a negedge; W is presented w_lead cycles ahead of AW.
  task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int w_lead);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    logic [1:0] exp_b;
    push_wr(a, d, s);
    aw_done = 0; w_done = 0; cyc = 0;
    wvalid = 1; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 50) begin
      if (cyc == w_lead) begin awvalid = 1; awaddr = a; end
      if (cyc > 0 && cyc < w_lead) begin
        chk("aw_rdy_wait", awready, 1);
        chk("w_rdy_wait", wready, 0);
      end
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      step();
      cyc++;
      if (aw_hs) begin awvalid = 0; aw_done = 1; end
      if (w_hs)  begin wvalid = 0;  w_done = 1;  end
    end
    if (!(aw_done && w_done)) chk("wr_timeout", 0, 1);
    chk("bvalid", bvalid, 1);
    chk("awrdy_in_resp", awready, 0);
    if (q_b.size() == 0) chk("bq_empty", 0, 1);
    else begin
      exp_b = q_b.pop_front();
      chk("bresp", bresp, exp_b);
    end
    bready = 1;
    step();
    bready = 0;
    chk("bvalid_clr", bvalid, 0);
  endtask

  task automatic axi_rd(input logic [31:0] a, input int hold);
    int cyc;
    logic [33:0] exp_r;
    push_rd(a);
    arvalid = 1; araddr = a; cyc = 0;
    while (!arready && cyc < 50) begin step(); cyc++; end
    if (!arready) chk("rd_timeout", 0, 1);
    step();
    arvalid = 0;
    chk("rvalid", rvalid, 1);
    if (q_r.size() == 0) begin
      chk("rq_empty", 0, 1);
      exp_r = '0;
    end else exp_r = q_r.pop_front();
    chk("rdata", rdata, exp_r[31:0]);
    chk("rresp", rresp, exp_r[33:32]);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_rvalid", rvalid, 1);
      chk("hold_rdata", rdata, exp_r[31:0]);
      chk("hold_arready", arready, 0);
    end
    rready = 1;
    step();
    rready = 0;
    chk("rvalid_clr", rvalid, 0);
    chk("arready_back", arready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    areset = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 4'hF; wvalid = 0;
    bready = 0; araddr = 0; arvalid = 0; rready = 0;
    @(negedge aclk);
    step(); step();
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resp", {28'h0, bresp, rresp}, 0);
    areset = 0;
    step();
    chk("post_rst_awready", awready, 1);
    chk("post_rst_arready", arready, 1);

    axi_rd(32'h0, 0);
    axi_wr(32'h8, 32'hDEAD_BEEF, 4'hF, 0);
    axi_rd(32'h8, 0);
    axi_wr(32'h4, 32'h1234_5678, 4'hF, 2);
    axi_rd(32'h4, 0);
    // Out-of-range write must not alias onto index 0.
    axi_wr(32'h40, 32'hCAFE_F00D, 4'hF, 0);
    axi_rd(32'h40, 0);
    axi_rd(32'h0, 0);
    axi_rd(32'h8, 3);
    // Unaligned address bits are ignored.
    axi_rd(32'h7, 0);
    axi_wr(32'hC, 32'hAAAA_AAAA, 4'hF, 1);
    axi_wr(32'hC, 32'h5555_5555, 4'b0011, 0);
    axi_rd(32'hC, 0);
    axi_wr(32'h3C, 32'h0BAD_F00D, 4'hF, 0);
    axi_rd(32'h3C, 0);

    // Reset while a write response is pending.
    awvalid = 1; awaddr = 32'h10; wvalid = 1; wdata = 32'h1; wstrb = 4'hF;
    step();
    awvalid = 0; wvalid = 0;
    chk("abort_bvalid_pre", bvalid, 1);
    areset = 1;
    step();
    chk("abort_bvalid", bvalid, 0);
    areset = 0;
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    step();
    axi_rd(32'h8, 0);
    axi_rd(32'h10, 0);

    if (q_b.size() != 0 || q_r.size() != 0) chk("sb_leftover", q_b.size() + q_r.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
- AXI4-Lite responder (slave) that terminates the master's five channels and backs them with a register file of NUM_REGS 32-bit words.
- Serves as the DUT-side endpoint opposite the master driven by the testbench BFM, so that write-then-read transactions can be checked end to end.
- Write path and read path are independent FSMs sharing one register array.

Parameters:
- NUM_REGS, 16, number of 32-bit registers; legal byte addresses are 0 .. NUM_REGS*4-1.
- RESET_VAL, 32'h0000_0000, value loaded into every register on reset.

Ports:
- aclk  in  1  clock; all logic on posedge.
- areset  in  1  synchronous, active-high reset.
- awaddr  in  addr_t  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  data_t  write data.
- wstrb  in  4  byte strobes; used only with the optional feature.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- araddr  in  addr_t  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  data_t  read data.
- rresp  out  2  read response.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.

Behaviour:
- Single clock, aclk. Reset is synchronous and active-high on areset, sampled at posedge aclk.
- Reset values: awready=0, wready=0, arready=0, bvalid=0, rvalid=0, bresp=OKAY, rresp=OKAY, rdata=0. All registers are set to RESET_VAL and both FSMs go to IDLE. Ready outputs rise in the first cycle after areset deasserts.
- Asserting reset mid-transaction aborts it: no write commits in that cycle and pending valids drop.
- Address decode:
  - idx = addr[2 +: $clog2(NUM_REGS)]; addr[1:0] are ignored.
  - Any address >= NUM_REGS*4 is out of range and gets resp=SLVERR (2'b10).
  - OKAY=2'b00.
- Write FSM, states W_IDLE -> W_RESP:
  - In W_IDLE, awready=!aw_held and wready=!w_held. The AW and W handshakes are accepted independently, in any order or in the same cycle, and are latched into aw_held/w_held.
  - When both are held (including the cycle of the second handshake), the FSM moves to W_RESP. The register update happens on that same edge; an out-of-range write is discarded.
  - Entering W_RESP: bvalid=1 and bresp is set; awready=wready=0.
  - On bvalid&&bready the FSM returns to W_IDLE and clears the held flags.
  - bvalid/bresp stay stable until accepted.
  - Minimum latency: AW+W handshake at edge N -> bvalid high after edge N.
- Read FSM, states R_IDLE -> R_DATA:
  - In R_IDLE, arready=1. The arvalid&&arready handshake captures the register (or 0 with SLVERR) into rdata/rresp and sets rvalid on the same edge: one-cycle latency.
  - In R_DATA, arready=0. On rvalid&&rready the FSM returns to R_IDLE. rdata/rresp stay stable while rvalid&&!rready.
  - There is no back-to-back overlap: the next AR is accepted no earlier than the cycle after the R handshake.
- Simultaneous read and write to the same register on the same edge: the read returns the pre-write value, and the write commits.
- Throughput: at most one write per 2 cycles and one read per 2 cycles.

Optional Feature:
- Macro: AXI_LITE_STRB_EN.
- Defined: byte lane i of the register is updated only if wstrb[i]=1. wstrb=4'b0000 is a legal no-op that returns OKAY.
- Undefined: wstrb is ignored and the full word is always written.

Decomposition:
- The following go in axi_lite_pkg: addr_t, data_t, a resp_t enum (OKAY=2'b00, SLVERR=2'b10), and the localparam for byte-address LSB.
- The FSM state enums (w_state_t, r_state_t) stay local to the module.
- One natural sub-module, axi_lite_regfile: the register array with one write port (idx, data, strb, en) and one combinational read port. It owns reset-to-RESET_VAL and the optional strobe masking.

Test Plan:
- Reset then read addr 0x0 -> rvalid one cycle after AR handshake, rdata=32'h0, rresp=OKAY.
- AW=0x8 and W=32'hDEAD_BEEF in the same cycle, bready=1, then read 0x8 -> bresp=OKAY, then rdata=32'hDEAD_BEEF.
- W=32'h1234_5678 two cycles before AW=0x4 -> awready stays 1 while wready=0 during the wait; bvalid follows the AW handshake; read 0x4 returns 32'h1234_5678.
- Write 0x40 (NUM_REGS=16) -> bresp=SLVERR and no register changes. Read 0x40 -> rdata=0, rresp=SLVERR.
- Hold rready=0 for 3 cycles after a read of 0x8 -> rvalid and rdata stay stable and arready=0; the FSM recovers after rready=1.
- With AXI_LITE_STRB_EN: 0xC holds 32'hAAAA_AAAA; write 32'h5555_5555 with wstrb=4'b0011 -> read returns 32'hAAAA_5555. Without the macro the same stimulus reads back 32'h5555_5555.
